// File: rtl/ldpc_parity_serializer_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_parity_serializer_pkg
//   Shared definitions for the LDPC parity serializer: FSM state encoding,
//   DVB-S2 parity-word counts per normal FECFRAME (360-bit parity groups),
//   and the word-count clamp helper used when a frame is started.
//   No ports (package).
// ---------------------------------------------------------------------------
package ldpc_parity_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Parity words (360 bits each) per normal FECFRAME for a few code rates.
  localparam int unsigned PAR_WORDS_R1_2  = 32'd90;
  localparam int unsigned PAR_WORDS_R3_5  = 32'd72;
  localparam int unsigned PAR_WORDS_R2_3  = 32'd60;
  localparam int unsigned PAR_WORDS_R3_4  = 32'd45;
  localparam int unsigned PAR_WORDS_R9_10 = 32'd18;

  // Requested word count limited to what the RAM can hold.
  function automatic logic [31:0] clamp_words(input logic [31:0] n,
                                              input logic [31:0] depth);
    logic [31:0] r;
    if (n > depth) begin
      r = depth;
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/ldpc_word_unpacker.sv
// ---------------------------------------------------------------------------
// ldpc_word_unpacker
//   Holds one RAM word and presents it OUT_WIDTH bits at a time, MSB first.
//   Ports:
//     clk, rst_n    clock, async active-low reset
//     load_i        capture data_i, byte index back to 0
//     shift_i       advance to the next byte (ignored when load_i is high)
//     data_i        word to capture
//     byte_o        current byte (top OUT_WIDTH bits of the shift register)
//     last_byte_o   current byte is the final one of the word
// ---------------------------------------------------------------------------
module ldpc_word_unpacker #(
  parameter int DATA_WIDTH = 360,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [OUT_WIDTH-1:0]  byte_o,
  output logic                  last_byte_o
);

  localparam int BPW   = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  // Next-state for shift register and byte index.
  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    if (load_i) begin
      sreg_d = data_i;
      idx_d  = {IDX_W{1'b0}};
    end else if (shift_i) begin
      sreg_d = {sreg_q[DATA_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
      idx_d  = idx_q + IDX_W'(1);
    end else begin
      sreg_d = sreg_q;
      idx_d  = idx_q;
    end
  end

  // Shift register and byte index state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= {DATA_WIDTH{1'b0}};
      idx_q  <= {IDX_W{1'b0}};
    end else begin
      sreg_q <= sreg_d;
      idx_q  <= idx_d;
    end
  end

  assign byte_o      = sreg_q[DATA_WIDTH-1 -: OUT_WIDTH];
  assign last_byte_o = (idx_q == IDX_W'(BPW - 1));

endmodule

// File: rtl/ldpc_parity_serializer.sv
// ---------------------------------------------------------------------------
// ldpc_parity_serializer
//   Reads num_words parity words (addresses 0..n-1) from a 1-cycle-latency
//   RAM and streams them out as AXI-Stream bytes, MSB first, one byte per
//   cycle. The next word is prefetched while the current one is shifted, and
//   rd_data0 is held by the RAM until the next read, so the word boundary
//   costs no bubble. m_tdata/m_tvalid/m_tlast come from an output register
//   fed by the unpacker.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     start, num_words      frame request (count clamped to DEPTH), idle only
//     busy, done            frame in progress / 1-cycle completion pulse
//     re0, rd_addr0         RAM read port
//     rd_data0              RAM read data (valid the cycle after re0)
//     m_tdata, m_tvalid,
//     m_tready, m_tlast     AXI-Stream byte output
//   The prefetch for word k+1 returns one edge after it is issued, so a word
//   must span at least two bytes (DATA_WIDTH >= 2*OUT_WIDTH).
// ---------------------------------------------------------------------------
module ldpc_parity_serializer
  import ldpc_parity_serializer_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 360,
  parameter int DEPTH      = 72,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  re0,
  output logic [ADDR_WIDTH-1:0] rd_addr0,
  input  logic [DATA_WIDTH-1:0] rd_data0,
  output logic [OUT_WIDTH-1:0]  m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;     // words in this frame
  logic [CNT_W-1:0]      loaded_q, loaded_d;   // words loaded into unpacker
  logic                  pf_valid_q, pf_valid_d;   // next word waits on rd_data0
  logic                  src_valid_q, src_valid_d; // unpacker holds unsent bytes
  logic                  re0_q, re0_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [OUT_WIDTH-1:0]  tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;

  logic                  up_load_s, up_shift_s, up_last_s;
  logic [OUT_WIDTH-1:0]  up_byte_s;
  logic [CNT_W-1:0]      count_in_s;
  logic [CNT_W-1:0]      next_loaded_s;
  logic                  out_free_s;

  ldpc_word_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_unpacker (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (up_load_s),
    .shift_i     (up_shift_s),
    .data_i      (rd_data0),
    .byte_o      (up_byte_s),
    .last_byte_o (up_last_s)
  );

  assign count_in_s    = CNT_W'(clamp_words(32'(num_words), 32'(DEPTH)));
  assign next_loaded_s = loaded_q + CNT_W'(1);
  // Output register can take a new byte when empty or being drained.
  assign out_free_s    = !tvalid_q || m_tready;

  // FSM next-state, counters, RAM read requests and output register.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    loaded_d    = loaded_q;
    pf_valid_d  = pf_valid_q;
    src_valid_d = src_valid_q;
    re0_d       = 1'b0;
    rd_addr_d   = rd_addr_q;
    busy_d      = busy_q;
    done_d      = (state_q == ST_DONE);
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    up_load_s   = 1'b0;
    up_shift_s  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          count_d     = count_in_s;
          loaded_d    = {CNT_W{1'b0}};
          pf_valid_d  = 1'b0;
          src_valid_d = 1'b0;
          if (count_in_s == {CNT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_READ;
            re0_d     = 1'b1;
            rd_addr_d = {ADDR_WIDTH{1'b0}};
            busy_d    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        // Word 0 is on rd_data0; capture it and prefetch word 1.
        up_load_s   = 1'b1;
        src_valid_d = 1'b1;
        loaded_d    = next_loaded_s;
        if (next_loaded_s < count_q) begin
          re0_d      = 1'b1;
          rd_addr_d  = next_loaded_s[ADDR_WIDTH-1:0];
          pf_valid_d = 1'b1;
        end else begin
          pf_valid_d = 1'b0;
        end
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (src_valid_q && out_free_s) begin
          tdata_d  = up_byte_s;
          tvalid_d = 1'b1;
          tlast_d  = up_last_s && !pf_valid_q;
          if (up_last_s) begin
            if (pf_valid_q) begin
              // Swap in the prefetched word and request the following one.
              up_load_s = 1'b1;
              loaded_d  = next_loaded_s;
              if (next_loaded_s < count_q) begin
                re0_d      = 1'b1;
                rd_addr_d  = next_loaded_s[ADDR_WIDTH-1:0];
                pf_valid_d = 1'b1;
              end else begin
                pf_valid_d = 1'b0;
              end
            end else begin
              src_valid_d = 1'b0;
            end
          end else begin
            up_shift_s = 1'b1;
          end
        end else if (!src_valid_q && tvalid_q && m_tready) begin
          // Final beat accepted.
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tdata_d  = {OUT_WIDTH{1'b0}};
          busy_d   = 1'b0;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_SEND;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        src_valid_d = 1'b0;
        pf_valid_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= {CNT_W{1'b0}};
      loaded_q    <= {CNT_W{1'b0}};
      pf_valid_q  <= 1'b0;
      src_valid_q <= 1'b0;
      re0_q       <= 1'b0;
      rd_addr_q   <= {ADDR_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tdata_q     <= {OUT_WIDTH{1'b0}};
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      loaded_q    <= loaded_d;
      pf_valid_q  <= pf_valid_d;
      src_valid_q <= src_valid_d;
      re0_q       <= re0_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign re0      = re0_q;
  assign rd_addr0 = rd_addr_q;
  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;

endmodule

// File: tb/tb_ldpc_parity_serializer.sv
// Self-checking bench for ldpc_parity_serializer. RAM word w, byte b holds
// (45*w + b) mod 256, so frame beat i must carry i mod 256.
module tb_ldpc_parity_serializer;

  localparam int AW  = 7;
  localparam int DW  = 360;
  localparam int OW  = 8;
  localparam int BPW = 45;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_words;
  logic          busy, done, re0;
  logic [AW-1:0] rd_addr0;
  logic [DW-1:0] rd_data0 = '0;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;

  logic [DW-1:0] mem [0:127];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Monitor bookkeeping (written by the monitor only)
  int beat_total = 0, re_total = 0, done_total = 0, vtot = 0;
  int rise_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  logic prev_stall = 1'b0, prev_v = 1'b0, prev_last = 1'b0;
  logic [OW-1:0] prev_data = '0;
  // Frame context (written by the main flow only)
  int beat_base = 0, re_base = 0, exp_words = 0;

  ldpc_parity_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .re0       (re0),
    .rd_addr0  (rd_addr0),
    .rd_data0  (rd_data0),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 1-cycle read latency, data held until the next read.
  always @(posedge clk) begin
    if (re0) rd_data0 <= mem[rd_addr0];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_v     <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", 32'(m_tvalid), 32'd1);
        check_val("hold_data", 32'(m_tdata), 32'(prev_data));
        check_val("hold_last", 32'(m_tlast), 32'(prev_last));
      end
      prev_stall <= m_tvalid && !m_tready;
      prev_data  <= m_tdata;
      prev_last  <= m_tlast;
      prev_v     <= m_tvalid;
      if (m_tvalid && !prev_v) rise_cyc <= cyc;
      if (m_tvalid) vtot <= vtot + 1;
      if (m_tvalid && m_tready) begin
        check_val("tdata", 32'(m_tdata), 32'((beat_total - beat_base) % 256));
        check_val("tlast", 32'(m_tlast),
                  32'((beat_total - beat_base) == exp_words * BPW - 1));
        beat_total  <= beat_total + 1;
        last_hs_cyc <= cyc;
      end
      if (re0) begin
        check_val("rd_addr", 32'(rd_addr0), 32'(re_total - re_base));
        re_total <= re_total + 1;
      end
      if (done) begin
        done_total <= done_total + 1;
        done_cyc   <= cyc;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"},   32'(busy), 32'd0);
    check_val({tag, "_done"},   32'(done), 32'd0);
    check_val({tag, "_re0"},    32'(re0), 32'd0);
    check_val({tag, "_addr"},   32'(rd_addr0), 32'd0);
    check_val({tag, "_tdata"},  32'(m_tdata), 32'd0);
    check_val({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    check_val({tag, "_tlast"},  32'(m_tlast), 32'd0);
  endtask

  // One frame: request n_req words, expect n_exp; optional random tready and
  // a stray start pulse restart_at cycles into the frame.
  task automatic run_frame(input int n_req, input int n_exp, input bit rnd, input int restart_at);
    int n_cyc, done0, v0;
    beat_base = beat_total;
    re_base   = re_total;
    exp_words = n_exp;
    done0     = done_total;
    v0        = vtot;
    @(posedge clk); #1;
    m_tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start     = 1'b1;
    num_words = 8'(n_req);
    n_cyc     = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    if (rnd) m_tready = 1'($urandom_range(0, 1));
    check_val("busy_after_start", 32'(busy), (n_exp > 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < 20000 && done_total == done0; i++) begin
      @(posedge clk); #1;
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      if (restart_at > 0 && i == restart_at) begin
        start     = 1'b1;
        num_words = 8'd5;
      end else begin
        start = 1'b0;
      end
    end
    start    = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("done_count", 32'(done_total - done0), 32'd1);
    check_val("beat_count", 32'(beat_total - beat_base), 32'(n_exp * BPW));
    check_val("re0_count", 32'(re_total - re_base), 32'(n_exp));
    check_val("busy_end", 32'(busy), 32'd0);
    check_val("tvalid_end", 32'(m_tvalid), 32'd0);
    if (n_exp > 0) begin
      check_val("first_valid_cyc", 32'(rise_cyc - n_cyc), 32'd3);
      check_val("done_after_last", 32'(done_cyc - last_hs_cyc), 32'd2);
      if (!rnd) check_val("no_bubble", 32'(last_hs_cyc - rise_cyc), 32'(n_exp * BPW - 1));
    end else begin
      check_val("no_tvalid", 32'(vtot - v0), 32'd0);
      check_val("zero_done_cyc", 32'(done_cyc - n_cyc), 32'd1);
    end
  endtask

  initial begin
    int d0;
    rst_n     = 1'b0;
    start     = 1'b0;
    num_words = '0;
    m_tready  = 1'b1;
    for (int w = 0; w < 128; w++) begin
      mem[w] = '0;
      if (w < 72) begin
        for (int b = 0; b < BPW; b++) mem[w][DW-1-8*b -: 8] = 8'((w * BPW + b) % 256);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(1, 1, 1'b0, 0);      // single word
    run_frame(72, 72, 1'b0, 0);    // full frame, back-to-back beats
    run_frame(4, 4, 1'b1, 0);      // random backpressure
    run_frame(0, 0, 1'b0, 0);      // empty frame
    run_frame(100, 72, 1'b0, 0);   // clamped to DEPTH

    // Reset in the middle of a frame
    beat_base = beat_total;
    re_base   = re_total;
    exp_words = 72;
    d0        = done_total;
    @(posedge clk); #1;
    start     = 1'b1;
    num_words = 8'd72;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000 && (beat_total - beat_base) < 100; i++) @(posedge clk);
    check_val("beats_before_reset", 32'((beat_total - beat_base) >= 100), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (5) @(posedge clk);
    #1;
    check_val("no_done_on_reset", 32'(done_total - d0), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(2, 2, 1'b0, 0);

    run_frame(3, 3, 1'b0, 10);     // stray start while busy

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
